// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the round-robin 4:1 mux arbiter.
//   NUM_REQ  : number of requesters sharing the channel
//   state_t  : arbiter FSM encoding (IDLE / GRANT)
//   LAST_RST : reset value of the round-robin pointer; 3 makes requester 0
//              the first one searched after reset
package mux_rr_arbiter_pkg;
  localparam int NUM_REQ = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [1:0] LAST_RST = 2'd3;
endpackage

// File: rtl/mux_rr_arbiter_pick.sv
// rr_pick4: combinational round-robin search over four requesters.
//   req   : raw request vector
//   mask  : requesters excluded from this search (e.g. the timed-out owner)
//   last  : previous owner; search order is last+1, last+2, last+3, last
//   idx   : first eligible index in that order
//   found : 1 when any eligible request exists
module rr_pick4
  import mux_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic [1:0]         last,
  output logic [1:0]         idx,
  output logic               found
);
  logic [NUM_REQ-1:0] elig;
  logic [1:0]         cand;

  assign elig = req & ~mask;

  // Walk from the farthest offset to the nearest so the nearest eligible
  // candidate is the one left standing. Offset 4 wraps to 'last' itself.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 4; k >= 1; k--) begin
      cand = last + 2'(k);
      if (elig[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter owning the select of a 4:1 data mux.
//   clk, reset_n   : clock, asynchronous active-low reset
//   req[3:0]       : level-sensitive requests
//   in0..in3       : requester data
//   gnt[3:0]       : registered one-hot grant (zero when idle)
//   sel[1:0]       : registered index of the owner; keeps last owner when idle
//   busy           : registered, high while an owner holds the channel
//   out            : data of the owner while busy, else 0
// An owner keeps the grant until it drops req, or until it has held for
// MAX_HOLD cycles while someone else waits; handover has no idle bubble.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int DW       = 1,
  parameter int MAX_HOLD = 8,
  parameter int CW       = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [DW-1:0]      in0,
  input  logic [DW-1:0]      in1,
  input  logic [DW-1:0]      in2,
  input  logic [DW-1:0]      in3,
  output logic [NUM_REQ-1:0] gnt,
  output logic [1:0]         sel,
  output logic               busy,
  output logic [DW-1:0]      out
);
  state_t       state;
  logic [CW-1:0] hold_cnt;
  logic [1:0]    last;

  logic [NUM_REQ-1:0] pmask;
  logic [1:0]         plast, pidx;
  logic               pfound, hold_max, rel;

  // While granted, the search starts after the current owner (it becomes
  // 'last' on release) and excludes it so a timed-out owner cannot win again.
  assign pmask    = (state == GRANT) ? gnt : '0;
  assign plast    = (state == GRANT) ? sel : last;
  assign hold_max = (hold_cnt == CW'(MAX_HOLD - 1));
  assign rel      = !req[sel] || (hold_max && ((req & ~gnt) != '0));

  rr_pick4 u_pick (
    .req   (req),
    .mask  (pmask),
    .last  (plast),
    .idx   (pidx),
    .found (pfound)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      gnt      <= '0;
      sel      <= '0;
      busy     <= 1'b0;
      hold_cnt <= '0;
      last     <= LAST_RST;
    end else begin
      case (state)
        IDLE: begin
          if (pfound) begin
            state    <= GRANT;
            gnt      <= 4'b0001 << pidx;
            sel      <= pidx;
            busy     <= 1'b1;
            hold_cnt <= '0;
          end
        end
        GRANT: begin
          if (rel) begin
            last     <= sel;
            hold_cnt <= '0;
            if (pfound) begin
              gnt <= 4'b0001 << pidx;
              sel <= pidx;
            end else begin
              state <= IDLE;
              gnt   <= '0;
              busy  <= 1'b0;
            end
          end else if (!hold_max) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    out = '0;
    if (busy) begin
      case (sel)
        2'd0:    out = in0;
        2'd1:    out = in1;
        2'd2:    out = in2;
        default: out = in3;
      endcase
    end
  end
endmodule
